// File: rtl/milano_pkg.sv
// Shared integer-pipeline types: register-file geometry and the writeback
// request carried from the result producers to the register file.
package milano_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] waddr;
    logic [XLEN-1:0]   wdata;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LSU  = 2'd2
  } wb_src_e;

endpackage

// File: rtl/wb_ctrl_if.sv
// Result, scoreboard and register-file write signals of the writeback stage;
// master is the pipeline side, slave is wb_ctrl.
interface wb_ctrl_if;
  import milano_pkg::*;

  logic              alu_valid_i;
  logic [REG_AW-1:0] alu_waddr_i;
  logic [XLEN-1:0]   alu_wdata_i;
  logic              alu_stall_o;
  logic              lsu_valid_i;
  logic              lsu_ready_o;
  logic [REG_AW-1:0] lsu_waddr_i;
  logic [XLEN-1:0]   lsu_wdata_i;
  logic              sb_set_i;
  logic [REG_AW-1:0] sb_addr_i;
  logic [XLEN-1:0]   pending_o;
  logic              rf_we_o;
  logic [REG_AW-1:0] rf_waddr_o;
  logic [XLEN-1:0]   rf_wdata_o;

  modport master (
    output alu_valid_i, alu_waddr_i, alu_wdata_i,
    output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    output sb_set_i, sb_addr_i,
    input  alu_stall_o, lsu_ready_o, pending_o,
    input  rf_we_o, rf_waddr_o, rf_wdata_o
  );

  modport slave (
    input  alu_valid_i, alu_waddr_i, alu_wdata_i,
    input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    input  sb_set_i, sb_addr_i,
    output alu_stall_o, lsu_ready_o, pending_o,
    output rf_we_o, rf_waddr_o, rf_wdata_o
  );

endinterface

// File: rtl/wb_ctrl_chk.sv
// Protocol and invariant checks for the writeback controller.
module wb_ctrl_chk (
  input logic clk_i,
  input logic rst_i,
  input logic alu_stall_i,
  input logic alu_valid_i,
  input logic pending0_i,
  input logic rf_we_i,
  input logic rf_waddr_zero_i
);

  a_no_alu_during_drain: assert property (@(posedge clk_i) disable iff (rst_i)
    alu_stall_i |-> !alu_valid_i);

  a_x0_never_pending: assert property (@(posedge clk_i) disable iff (rst_i)
    !pending0_i);

  a_x0_never_written: assert property (@(posedge clk_i) disable iff (rst_i)
    rf_we_i |-> !rf_waddr_zero_i);

endmodule

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback requests; head is visible combinationally
// so a pop and the write it feeds happen in the same cycle.
module wb_fifo
  import milano_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  wb_req_t                din_i,
  input  logic                   pop_i,
  output wb_req_t                dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_req_t         mem_q [DEPTH];
  wb_req_t         mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push_s, do_pop_s;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == CW'(0));
  assign count_o   = count_q;
  assign dout_o    = mem_q[rd_ptr_q];
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = din_i;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (do_push_s && !do_pop_s) begin
      count_d = count_q + CW'(1);
    end else if (do_pop_s && !do_push_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/wb_ctrl.sv
// Writeback controller: arbitrates ALU results against the buffered LSU/MDU
// results for the single register-file write port and tracks pending loads.
module wb_ctrl
  import milano_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input logic     clk_i,
  input logic     rst_i,
  wb_ctrl_if.slave wb
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  wb_req_t           lsu_req_s, fifo_head_s, win_s;
  wb_src_e           src_s;
  logic              fifo_full_s, fifo_empty_s, push_s, pop_s, forced_s;
  logic [CW-1:0]     fifo_count_s;
  logic [SW-1:0]     starve_q, starve_d;
  logic              alu_stall_q, alu_stall_d;
  logic              rf_we_q, rf_we_d;
  logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
  logic [XLEN-1:0]   pending_q, pending_d;

  assign lsu_req_s      = '{waddr: wb.lsu_waddr_i, wdata: wb.lsu_wdata_i};
  assign wb.lsu_ready_o = (fifo_count_s < CW'(DEPTH));
  assign push_s         = wb.lsu_valid_i && !fifo_full_s;
  assign forced_s       = (starve_q == SW'(STARVE_MAX));
  assign pop_s          = (src_s == SRC_LSU);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_s),
    .din_i   (lsu_req_s),
    .pop_i   (pop_s),
    .dout_o  (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  // Pick this cycle's writer; a starved FIFO beats the ALU.
  always_comb begin
    src_s = SRC_NONE;
    win_s = '0;
    if (forced_s) begin
      src_s = SRC_LSU;
    end else if (wb.alu_valid_i) begin
      src_s = SRC_ALU;
    end else if (!fifo_empty_s) begin
      src_s = SRC_LSU;
    end else begin
      src_s = SRC_NONE;
    end
    case (src_s)
      SRC_ALU: win_s = '{waddr: wb.alu_waddr_i, wdata: wb.alu_wdata_i};
      SRC_LSU: win_s = fifo_head_s;
      default: win_s = '0;
    endcase
  end

  // Next-state for write port, starvation tracking and pending scoreboard.
  always_comb begin
    rf_we_d    = (src_s != SRC_NONE) && (win_s.waddr != 5'd0);
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (src_s != SRC_NONE) begin
      rf_waddr_d = win_s.waddr;
      rf_wdata_d = win_s.wdata;
    end else begin
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
    end

    starve_d = starve_q;
    if (pop_s || fifo_empty_s) begin
      starve_d = '0;
    end else if ((src_s == SRC_ALU) && !forced_s) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end
    alu_stall_d = (starve_d == SW'(STARVE_MAX));

    // Clear before set so a same-cycle reissue to the same register survives.
    pending_d = pending_q;
    if ((src_s == SRC_LSU) && rf_we_d) begin
      pending_d[win_s.waddr] = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    if (wb.sb_set_i && (wb.sb_addr_i != 5'd0)) begin
      pending_d[wb.sb_addr_i] = 1'b1;
    end else begin
      pending_d[0] = 1'b0;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= 5'd0;
      rf_wdata_q  <= 32'd0;
      starve_q    <= '0;
      alu_stall_q <= 1'b0;
      pending_q   <= 32'd0;
    end else begin
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      starve_q    <= starve_d;
      alu_stall_q <= alu_stall_d;
      pending_q   <= pending_d;
    end
  end

  assign wb.rf_we_o     = rf_we_q;
  assign wb.rf_waddr_o  = rf_waddr_q;
  assign wb.rf_wdata_o  = rf_wdata_q;
  assign wb.alu_stall_o = alu_stall_q;
  assign wb.pending_o   = pending_q;

  wb_ctrl_chk u_chk (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .alu_stall_i     (alu_stall_q),
    .alu_valid_i     (wb.alu_valid_i),
    .pending0_i      (pending_q[0]),
    .rf_we_i         (rf_we_q),
    .rf_waddr_zero_i (rf_waddr_q == 5'd0)
  );

endmodule

// File: tb/tb_wb_ctrl.sv
// Directed bench for wb_ctrl: stimulus queues expected register-file writes,
// a negedge monitor pops and compares every write the DUT issues.
module tb_wb_ctrl;
  import milano_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  wb_ctrl_if bus ();

  wb_ctrl #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .wb    (bus)
  );

  int      checks = 0;
  int      errors = 0;
  wb_req_t exp_q[$];
  wb_req_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid_i = 1'b0;
    bus.alu_waddr_i = 5'd0;
    bus.alu_wdata_i = 32'd0;
    bus.lsu_valid_i = 1'b0;
    bus.lsu_waddr_i = 5'd0;
    bus.lsu_wdata_i = 32'd0;
    bus.sb_set_i    = 1'b0;
    bus.sb_addr_i   = 5'd0;
  endtask

  task automatic drive_alu(input logic [4:0] a, input logic [31:0] d);
    bus.alu_valid_i = 1'b1;
    bus.alu_waddr_i = a;
    bus.alu_wdata_i = d;
  endtask

  task automatic drive_lsu(input logic [4:0] a, input logic [31:0] d);
    bus.lsu_valid_i = 1'b1;
    bus.lsu_waddr_i = a;
    bus.lsu_wdata_i = d;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back('{waddr: a, wdata: d});
  endtask

  // Scoreboard monitor: every issued write must match the oldest expectation.
  always @(negedge clk_i) begin
    if (!rst_i && bus.rf_we_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got x%0d=0x%08h, expected no write",
                 bus.rf_waddr_o, bus.rf_wdata_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.rf_waddr_o !== mon_e.waddr || bus.rf_wdata_o !== mon_e.wdata) begin
          errors++;
          $display("FAIL write_order: got x%0d=0x%08h, expected x%0d=0x%08h",
                   bus.rf_waddr_o, bus.rf_wdata_o, mon_e.waddr, mon_e.wdata);
        end
      end
    end
  end

  logic [15:0] stall_exp;
  logic [15:0] ready_exp;
  wb_req_t     lsu_tab [3];
  int          k;
  int          j;
  logic        take;

  initial begin
    idle_inputs();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("reset_rf_we", 32'(bus.rf_we_o), 32'd0);
    check("reset_rf_waddr", 32'(bus.rf_waddr_o), 32'd0);
    check("reset_rf_wdata", bus.rf_wdata_o, 32'd0);
    check("reset_stall", 32'(bus.alu_stall_o), 32'd0);
    check("reset_pending", bus.pending_o, 32'd0);
    check("reset_ready", 32'(bus.lsu_ready_o), 32'd1);
    tick();

    // ALU write lands one cycle later; x0 write is suppressed.
    drive_alu(5'd5, 32'h0000_1234);
    expect_wr(5'd5, 32'h0000_1234);
    tick();
    check("alu_we", 32'(bus.rf_we_o), 32'd1);
    check("alu_waddr", 32'(bus.rf_waddr_o), 32'd5);
    check("alu_wdata", bus.rf_wdata_o, 32'h0000_1234);
    drive_alu(5'd0, 32'h0000_DEAD);
    tick();
    check("alu_x0_we", 32'(bus.rf_we_o), 32'd0);
    bus.alu_valid_i = 1'b0;

    // Pending x7, LSU x7 written two cycles after handshake and clears pending.
    bus.sb_set_i  = 1'b1;
    bus.sb_addr_i = 5'd7;
    tick();
    check("sb_set7", bus.pending_o, 32'h0000_0080);
    bus.sb_set_i = 1'b0;
    drive_lsu(5'd7, 32'h0000_CAFE);
    check("lsu_ready_idle", 32'(bus.lsu_ready_o), 32'd1);
    expect_wr(5'd7, 32'h0000_CAFE);
    tick();
    bus.lsu_valid_i = 1'b0;
    check("lsu_n1_we", 32'(bus.rf_we_o), 32'd0);
    check("lsu_n1_pending", bus.pending_o, 32'h0000_0080);
    tick();
    check("lsu_n2_we", 32'(bus.rf_we_o), 32'd1);
    check("lsu_n2_waddr", 32'(bus.rf_waddr_o), 32'd7);
    check("lsu_n2_pending", bus.pending_o, 32'd0);

    // ALU and FIFO head contend with counter 0: ALU first, head next.
    drive_lsu(5'd10, 32'h0000_00A0);
    expect_wr(5'd11, 32'h0000_00B0);
    expect_wr(5'd10, 32'h0000_00A0);
    tick();
    bus.lsu_valid_i = 1'b0;
    drive_alu(5'd11, 32'h0000_00B0);
    tick();
    bus.alu_valid_i = 1'b0;
    check("contend_first", 32'(bus.rf_waddr_o), 32'd11);
    tick();
    check("contend_second_we", 32'(bus.rf_we_o), 32'd1);
    check("contend_second", 32'(bus.rf_waddr_o), 32'd10);

    // Same-cycle set and clear of x9: set wins.
    bus.sb_set_i  = 1'b1;
    bus.sb_addr_i = 5'd9;
    tick();
    bus.sb_set_i = 1'b0;
    drive_lsu(5'd9, 32'h0000_0099);
    expect_wr(5'd9, 32'h0000_0099);
    tick();
    bus.lsu_valid_i = 1'b0;
    bus.sb_set_i    = 1'b1;
    bus.sb_addr_i   = 5'd9;
    tick();
    bus.sb_set_i = 1'b0;
    check("x9_we", 32'(bus.rf_we_o), 32'd1);
    check("x9_waddr", 32'(bus.rf_waddr_o), 32'd9);
    check("x9_pending_kept", bus.pending_o, 32'h0000_0200);

    // Starvation: three LSU pushes against continuous ALU traffic.
    stall_exp  = 16'h8420;
    ready_exp  = 16'hF843;
    lsu_tab[0] = '{waddr: 5'd1, wdata: 32'h0000_0011};
    lsu_tab[1] = '{waddr: 5'd2, wdata: 32'h0000_0022};
    lsu_tab[2] = '{waddr: 5'd3, wdata: 32'h0000_0033};
    for (int a = 0; a < 13; a++) begin
      if (a == 5)  exp_q.push_back(lsu_tab[0]);
      if (a == 9)  exp_q.push_back(lsu_tab[1]);
      expect_wr(5'(16 + a), 32'h0000_A000 + 32'(a));
    end
    exp_q.push_back(lsu_tab[2]);
    k = 0;
    j = 0;
    for (int c = 0; c < 20; c++) begin
      if (c < 16) begin
        check($sformatf("stall_c%0d", c), 32'(bus.alu_stall_o), 32'(stall_exp[c]));
        check($sformatf("ready_c%0d", c), 32'(bus.lsu_ready_o), 32'(ready_exp[c]));
      end
      if (!bus.alu_stall_o && k < 13) begin
        drive_alu(5'(16 + k), 32'h0000_A000 + 32'(k));
        k++;
      end else begin
        bus.alu_valid_i = 1'b0;
      end
      take = 1'b0;
      if (j < 3) begin
        drive_lsu(lsu_tab[j].waddr, lsu_tab[j].wdata);
        take = bus.lsu_ready_o;
      end else begin
        bus.lsu_valid_i = 1'b0;
      end
      tick();
      if (take) j++;
    end
    idle_inputs();
    check("starve_lsu_accepted", 32'(j), 32'd3);
    tick();

    // Reset with two entries buffered and x7/x9 pending.
    bus.sb_set_i  = 1'b1;
    bus.sb_addr_i = 5'd7;
    tick();
    bus.sb_set_i = 1'b0;
    drive_lsu(5'd12, 32'h0000_1200);
    drive_alu(5'd20, 32'h0000_2000);
    expect_wr(5'd20, 32'h0000_2000);
    tick();
    drive_lsu(5'd13, 32'h0000_1300);
    drive_alu(5'd21, 32'h0000_2100);
    expect_wr(5'd21, 32'h0000_2100);
    check("pre_rst_ready1", 32'(bus.lsu_ready_o), 32'd1);
    tick();
    idle_inputs();
    check("pre_rst_full", 32'(bus.lsu_ready_o), 32'd0);
    check("pre_rst_pending", bus.pending_o, 32'h0000_0280);
    @(negedge clk_i);
    #1;
    rst_i = 1'b1;
    #1;
    check("rst_rf_we", 32'(bus.rf_we_o), 32'd0);
    check("rst_rf_waddr", 32'(bus.rf_waddr_o), 32'd0);
    check("rst_rf_wdata", bus.rf_wdata_o, 32'd0);
    check("rst_stall", 32'(bus.alu_stall_o), 32'd0);
    check("rst_pending", bus.pending_o, 32'd0);
    check("rst_ready", 32'(bus.lsu_ready_o), 32'd1);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (6) tick();
    check("post_rst_ready", 32'(bus.lsu_ready_o), 32'd1);
    check("post_rst_pending", bus.pending_o, 32'd0);
    check("post_rst_we", 32'(bus.rf_we_o), 32'd0);
    check("exp_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_ctrl.md
# wb_ctrl

Writeback controller that owns the single write port of the integer register file. It merges results from the single-cycle ALU path and the multi-cycle LSU/MDU path into one registered write per cycle, buffering LSU results in a small FIFO. It also keeps a pending-destination scoreboard so decode can stall on long-latency hazards.

## Interface
Parameters:
- DEPTH, 2, LSU result FIFO entries (power of two, ≥2)
- STARVE_MAX, 4, consecutive cycles a non-empty FIFO may lose arbitration before a forced drain

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- alu_valid_i  in  1  ALU result valid; no backpressure
- alu_waddr_i  in  5  ALU destination register
- alu_wdata_i  in  32  ALU result
- alu_stall_o  out  1  registered; upstream must hold alu_valid_i=0 in the next cycle
- lsu_valid_i  in  1  LSU/MDU result valid
- lsu_ready_o  out  1  FIFO can accept (count < DEPTH)
- lsu_waddr_i  in  5  LSU destination register
- lsu_wdata_i  in  32  LSU result
- sb_set_i  in  1  decode issued a long-latency op
- sb_addr_i  in  5  its destination register
- pending_o  out  32  bit r set = x_r awaiting LSU writeback; bit 0 always 0
- rf_we_o  out  1  register-file write enable (registered)
- rf_waddr_o  out  5  register-file write address (registered)
- rf_wdata_o  out  32  register-file write data (registered)

## Operation
- LSU handshake fires on lsu_valid_i & lsu_ready_o; entry {waddr, wdata} pushed to FIFO tail.
- lsu_ready_o = (count < DEPTH), from registered count only; a same-cycle pop does not raise it.
- Arbitration each cycle, priority order: (1) forced drain (alu_stall_o was high last cycle... i.e. starve counter == STARVE_MAX) → FIFO head; (2) alu_valid_i → ALU; (3) FIFO non-empty → FIFO head; (4) idle.
- Winner registered onto rf_*; rf_we_o = 1 only if winner's address ≠ 0. x0 writes are consumed (FIFO pops) but never reach the file.
- Starve counter: increments when FIFO non-empty and ALU wins; clears on any FIFO pop or FIFO empty; saturates at STARVE_MAX.
- alu_stall_o = registered (next counter == STARVE_MAX); in the following cycle FIFO head wins. alu_valid_i=1 during a forced drain is a protocol error (assertion); ALU result is dropped.
- Scoreboard: sb_set_i sets pending[sb_addr_i]; an LSU-sourced write with rf_we_o clears pending[rf_waddr_o] in the cycle it is registered. Same-cycle set and clear of the same address: set wins. sb_addr_i=0 ignored. ALU writes never touch pending.
- FIFO full with lsu_valid_i held: no push, data held upstream; pop in that cycle frees a slot visible next cycle.

## Timing
- Reset values: rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, alu_stall_o=0, pending_o=0, lsu_ready_o=1, FIFO empty, starve counter 0.
- Reset asserted mid-operation: FIFO contents and pending bits discarded immediately; no write issued after reset.
- ALU latency: alu_valid_i at cycle N → rf_we_o at N+1.
- LSU latency (uncontended): handshake at N → head at N+1 → rf_we_o at N+2.
- Sustained throughput: one register-file write per cycle.
- Register file forwards wdata in the write cycle, so decode sees results at rf_we_o cycle.

## Structure
- Shared package (milano_pkg): XLEN=32, REG_AW=5, wb_req_t {logic [4:0] waddr; logic [31:0] wdata}.
- One sub-module: wb_fifo (parameterised DEPTH sync FIFO of wb_req_t, push/pop/full/empty/count); arbitration, starve counter and scoreboard stay in wb_ctrl.

## Test plan
- ALU x5=0x1234 at cycle 3 → rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0x1234 at cycle 4; ALU write to x0 → rf_we_o stays 0.
- sb_set x7; LSU x7=0xCAFE accepted at N, no ALU → rf write at N+2 and pending_o[7] clears same cycle.
- Three LSU pushes back-to-back with continuous ALU traffic → lsu_ready_o drops after 2 accepts; alu_stall_o rises after STARVE_MAX=4 lost cycles; FIFO entries written in push order.
- ALU and FIFO head ready same cycle, counter 0 → ALU written first, FIFO head next cycle, writes never dropped.
- sb_set x9 in the cycle an LSU write to x9 is registered → pending_o[9] stays 1.
- rst_i asserted with FIFO holding 2 entries and pending_o=0x0000_0280 → all outputs return to reset values asynchronously; no write after release.
